// File: rtl/prdct_accum_if.sv
// Handshake bundle between the multiplier feed, the frame accumulator and the
// downstream consumer of frame totals.
interface prdct_accum_if #(
  parameter int PW = 12,
  parameter int CW = 2,
  parameter int AW = 14
);
  logic          in_valid;
  logic          in_ready;
  logic [PW-1:0] prdct;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] sum;
  logic [CW-1:0] beat_cnt;

  modport slave (
    input  in_valid, prdct, out_ready,
    output in_ready, out_valid, sum, beat_cnt
  );

  modport master (
    output in_valid, prdct, out_ready,
    input  in_ready, out_valid, sum, beat_cnt
  );
endinterface

// File: rtl/prdct_accum.sv
// Frame accumulator behind the 6x6 multiplier: sums N accepted products and
// holds each frame total on a valid/ready output until it is taken.
module prdct_accum #(
  parameter int PW = 12,
  parameter int N  = 4,
  parameter int CW = 2,
  parameter int AW = 14
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  prdct_accum_if.slave  bus
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t        state, state_nx;
  logic [AW-1:0] acc_p0;
  logic [CW-1:0] cnt_p0;
  logic [AW-1:0] sum_p1;
  logic          vld_p1;
  logic          rdy;
  logic          accept;
  logic          last_beat;

  // AW = PW + log2(N) leaves headroom for N full-scale products, so a plain
  // zero-extend is all the width handling the sum needs.
  function automatic logic [AW-1:0] widen(input logic [PW-1:0] p);
    widen = {{(AW-PW){1'b0}}, p};
  endfunction

  assign accept    = rdy & bus.in_valid & ~clr;
  assign last_beat = (cnt_p0 == CW'(N-1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ACCUM: if (accept && last_beat) state_nx = HOLD;
      HOLD:  if (bus.out_ready)       state_nx = ACCUM;
      default:                        state_nx = ACCUM;
    endcase
  end

  always_comb begin
    rdy    = (state == ACCUM);
    vld_p1 = (state == HOLD);
  end

  // Stage p0: running frame accumulation; clr only acts while collecting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_p0 <= '0;
      cnt_p0 <= '0;
      sum_p1 <= '0;
    end else if (rdy) begin
      if (clr) begin
        acc_p0 <= '0;
        cnt_p0 <= '0;
      end else if (bus.in_valid) begin
        if (last_beat) begin
          // Stage p1: frame total captured, held until the handshake.
          sum_p1 <= acc_p0 + widen(bus.prdct);
          acc_p0 <= '0;
          cnt_p0 <= '0;
        end else begin
          acc_p0 <= acc_p0 + widen(bus.prdct);
          cnt_p0 <= cnt_p0 + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = vld_p1;
  assign bus.sum       = sum_p1;
  assign bus.beat_cnt  = cnt_p0;

endmodule

// File: tb/tb_prdct_accum.sv
// Bench for prdct_accum: directed vector table followed by random traffic
// compared against a queue-based frame model.
module tb_prdct_accum;
  localparam int PW = 12;
  localparam int N  = 4;
  localparam int CW = 2;
  localparam int AW = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;

  always #5 clk = ~clk;

  prdct_accum_if #(.PW(PW), .CW(CW), .AW(AW)) bus ();

  prdct_accum #(.PW(PW), .N(N), .CW(CW), .AW(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .bus   (bus)
  );

  typedef struct {
    bit r;
    bit c;
    bit iv;
    int p;
    bit ordy;
    bit e_vld;
    int e_sum;
    int e_cnt;
    bit e_rdy;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  // Frame model: products accepted in the current frame, plus pending total.
  int   mq[$];
  bit   m_hold = 1'b0;
  int   m_sum  = 0;

  function automatic int mul6(input int x, input int y);
    mul6 = (x & 63) * (y & 63);
  endfunction

  task automatic add(input bit r, input bit c, input bit iv, input int p, input bit ordy,
                     input bit ev, input int es, input int ec, input bit er);
    vec_t v;
    v.r = r; v.c = c; v.iv = iv; v.p = p; v.ordy = ordy;
    v.e_vld = ev; v.e_sum = es; v.e_cnt = ec; v.e_rdy = er;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s step=%0d got=%0d want=%0d", name, idx, act, exp);
    end
  endtask

  task automatic model_step(input bit r, input bit c, input bit iv, input int p, input bit ordy);
    if (!r) begin
      mq.delete();
      m_hold = 1'b0;
      m_sum  = 0;
    end else if (!m_hold) begin
      if (c) mq.delete();
      else if (iv) begin
        mq.push_back(p);
        if (mq.size() == N) begin
          m_sum = mq.sum();
          mq.delete();
          m_hold = 1'b1;
        end
      end
    end else if (ordy) begin
      m_hold = 1'b0;
    end
  endtask

  task automatic cycle(input bit r, input bit c, input bit iv, input int p, input bit ordy);
    rst_n         = r;
    clr           = c;
    bus.in_valid  = iv;
    bus.prdct     = p[PW-1:0];
    bus.out_ready = ordy;
    @(posedge clk);
    model_step(r, c, iv, p, ordy);
    #1;
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.prdct     = '0;
    bus.out_ready = 1'b0;

    // basic frame
    add(0,0,0,0,1, 0,0,0,1);
    add(0,0,0,0,1, 0,0,0,1);
    add(1,0,1,3,1, 0,0,1,1);
    add(1,0,1,5,1, 0,0,2,1);
    add(1,0,1,7,1, 0,0,3,1);
    add(1,0,1,9,1, 1,24,0,0);
    add(1,0,0,0,1, 0,24,0,1);
    // max values
    add(1,0,1,3969,1, 0,24,1,1);
    add(1,0,1,3969,1, 0,24,2,1);
    add(1,0,1,3969,1, 0,24,3,1);
    add(1,0,1,3969,1, 1,15876,0,0);
    add(1,0,0,0,1, 0,15876,0,1);
    // input gaps
    add(1,0,1,10,1, 0,15876,1,1);
    add(1,0,0,0,1,  0,15876,1,1);
    add(1,0,0,0,1,  0,15876,1,1);
    add(1,0,0,0,1,  0,15876,1,1);
    add(1,0,1,20,1, 0,15876,2,1);
    add(1,0,0,0,1,  0,15876,2,1);
    add(1,0,1,30,1, 0,15876,3,1);
    add(1,0,1,40,1, 1,100,0,0);
    add(1,0,0,0,1,  0,100,0,1);
    // backpressure
    add(1,0,1,3,0, 0,100,1,1);
    add(1,0,1,5,0, 0,100,2,1);
    add(1,0,1,7,0, 0,100,3,1);
    add(1,0,1,9,0, 1,24,0,0);
    for (int i = 0; i < 5; i++) add(1,0,1,99,0, 1,24,0,0);
    add(1,0,0,0,1, 0,24,0,1);
    add(1,0,1,1,1, 0,24,1,1);
    add(1,0,1,1,1, 0,24,2,1);
    add(1,0,1,1,1, 0,24,3,1);
    add(1,0,1,1,1, 1,4,0,0);
    add(1,0,0,0,1, 0,4,0,1);
    // clr mid-frame
    add(1,0,1,100,1, 0,4,1,1);
    add(1,0,1,200,1, 0,4,2,1);
    add(1,1,1,50,1,  0,4,0,1);
    add(1,0,1,1,1, 0,4,1,1);
    add(1,0,1,2,1, 0,4,2,1);
    add(1,0,1,3,1, 0,4,3,1);
    add(1,0,1,4,1, 1,10,0,0);
    add(1,0,0,0,1, 0,10,0,1);
    // reset while holding
    add(1,0,1,3,0, 0,10,1,1);
    add(1,0,1,5,0, 0,10,2,1);
    add(1,0,1,7,0, 0,10,3,1);
    add(1,0,1,9,0, 1,24,0,0);
    add(1,0,0,0,0, 1,24,0,0);
    add(0,0,1,5,1, 0,0,0,1);
    add(1,0,1,2,0, 0,0,1,1);
    add(1,0,1,2,0, 0,0,2,1);
    add(1,0,1,2,0, 0,0,3,1);
    add(1,0,1,2,0, 1,8,0,0);
    add(1,0,0,0,1, 0,8,0,1);
    // products straight from the multiplier
    add(1,0,1,mul6(1,2),1, 0,8,1,1);
    add(1,0,1,mul6(3,4),1, 0,8,2,1);
    add(1,0,1,mul6(5,6),1, 0,8,3,1);
    add(1,0,1,mul6(7,8),1, 1,100,0,0);
    add(1,0,0,0,1, 0,100,0,1);
    // clr while holding has no effect
    add(1,0,1,1,0, 0,100,1,1);
    add(1,0,1,1,0, 0,100,2,1);
    add(1,0,1,1,0, 0,100,3,1);
    add(1,0,1,1,0, 1,4,0,0);
    add(1,1,1,7,0, 1,4,0,0);
    add(1,0,0,0,1, 0,4,0,1);

    foreach (vecs[i]) begin
      cycle(vecs[i].r, vecs[i].c, vecs[i].iv, vecs[i].p, vecs[i].ordy);
      check("vec_out_valid", i, int'(bus.out_valid), int'(vecs[i].e_vld));
      check("vec_sum",       i, int'(bus.sum),       vecs[i].e_sum);
      check("vec_beat_cnt",  i, int'(bus.beat_cnt),  vecs[i].e_cnt);
      check("vec_in_ready",  i, int'(bus.in_ready),  int'(vecs[i].e_rdy));
    end

    for (int i = 0; i < 400; i++) begin
      bit r, c, iv, ordy;
      int p;
      r    = ($urandom_range(0, 49) != 0);
      c    = ($urandom_range(0, 15) == 0);
      iv   = $urandom_range(0, 1) != 0;
      ordy = $urandom_range(0, 2) != 0;
      p    = mul6(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
      cycle(r, c, iv, p, ordy);
      check("rnd_out_valid", i, int'(bus.out_valid), int'(m_hold));
      check("rnd_sum",       i, int'(bus.sum),       m_sum);
      check("rnd_beat_cnt",  i, int'(bus.beat_cnt),  mq.size());
      check("rnd_in_ready",  i, int'(bus.in_ready),  int'(!m_hold));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/prdct_accum.md
Name: prdct_accum

Overview:
- Accumulator stage directly downstream of the 6x6 unsigned multiplier `multplr`.
- Consumes its 12-bit `prdct` output and sums frames of N consecutive products (dot-product style).
- Presents each frame total on a valid/ready output interface.
- Provides the sequential framing and backpressure that the combinational multiplier lacks.

Parameters:
- PW, 12, product width; matches the multiplier output.
- N, 4, products per frame; must be ≥2 and a power of two.
- CW, 2, frame-counter width; equals log2(N).
- AW, 14, accumulator/sum width; equals PW+CW, so overflow is impossible.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- clr  in  1  synchronous frame abort; priority below rst_n.
- in_valid  in  1  prdct holds a valid product this cycle.
- in_ready  out  1  block can accept a product this cycle.
- prdct  in  PW  unsigned product from multplr.
- out_valid  out  1  sum holds a completed frame total.
- out_ready  in  1  downstream accepts sum this cycle.
- sum  out  AW  unsigned frame total.
- beat_cnt  out  CW  products accepted so far in the current frame.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=ACCUM, acc=0, beat_cnt=0.
  - out_valid=0, sum=0, in_ready=1 from the following cycle.
  - All other inputs are ignored during reset.
- States:
  - ACCUM: collecting products.
  - HOLD: frame total presented, waiting for downstream.
- in_ready is registered: 1 in ACCUM, 0 in HOLD.
- Accept: in_valid & in_ready at a clk edge. prdct is zero-extended to AW.
- Accept with beat_cnt<N-1:
  - acc <= acc+prdct.
  - beat_cnt <= beat_cnt+1.
- Accept with beat_cnt==N-1 (last beat):
  - sum <= acc+prdct; acc <= 0; beat_cnt <= 0 (wraps).
  - out_valid <= 1, in_ready <= 0, state <= HOLD.
  - Latency: sum is valid exactly 1 cycle after the last accept.
- in_valid=0 in ACCUM: acc and beat_cnt hold. Gaps of any length are legal.
- HOLD:
  - sum and out_valid are stable until out_valid & out_ready.
  - On that edge: out_valid <= 0, in_ready <= 1, state <= ACCUM.
  - A new frame's first product can be accepted no earlier than the cycle after the handshake. Throughput: N+1 cycles per frame at best.
- out_ready is ignored while out_valid=0.
- prdct is ignored when in_valid=0 or in_ready=0.
- clr=1 in ACCUM:
  - acc <= 0, beat_cnt <= 0.
  - Any product offered in the same cycle is discarded.
- clr=1 in HOLD:
  - No effect. The completed frame is still delivered.
- rst_n=0 mid-frame or in HOLD:
  - Partial frame and pending sum are discarded.
  - out_valid drops to 0 on that edge with no handshake.
- Arithmetic:
  - Unsigned and width-exact. Max sum = N*(2^PW−1) < 2^AW.
  - No saturation logic.

Test Plan:
- Basic frame: rst_n low 2 cycles, then out_ready=1; feed prdct 3,5,7,9 back-to-back → 1 cycle after the 4th accept: out_valid=1, sum=24, beat_cnt=0. in_ready=0 for 1 cycle, then 1.
- Max values: four products of 63*63=3969 → sum=15876 (0x3E04), no wrap.
- Input gaps: offer 10, idle 3 cycles, offer 20, idle 1, offer 30, 40 → sum=100. beat_cnt reads 1, 1, 1, 1, 2, 2, 3 across the gap cycles.
- Backpressure: out_ready=0 for 5 cycles after the frame sum 24 → sum and out_valid stay stable, in_ready=0, and products offered meanwhile are not counted. Raise out_ready → handshake, then the next frame 1,1,1,1 gives sum=4.
- clr mid-frame: accept 100, 200, then clr=1 with in_valid=1 and prdct=50 → beat_cnt=0. Next frame 1,2,3,4 gives sum=10.
- Reset in HOLD: frame sum 24 pending with out_ready=0, then rst_n=0 for 1 cycle → out_valid=0, sum=0, in_ready=1. Next frame 2,2,2,2 gives sum=8.
- End-to-end with multplr: drive X,Y pairs (1,2), (3,4), (5,6), (7,8) into multplr and its prdct into this block → sum=100.
